regfile_multiport: RTL

- Parametrised successor to the processor's two-read/one-write register file.
- Configurable data width, address width and number of read ports.
- Synchronous registered reads with write-to-read bypass; optional hardwired zero register.
- Synchronous active-low reset starts a hardware clear sweep; `ready` flags when the file is usable.
- Sits between the decode stage (read addresses) and the writeback stage (write port) of the multicycle datapath.

---
 rtl/regfile_multiport.sv | 147 ++++++++++++++
 1 files changed

// File: rtl/regfile_multiport.sv
// regfile_multiport: parametrised multi-read, single-write register file.
// Reads are registered (1-cycle latency) with write-to-read bypass.
// ZERO_REG=1 hardwires register 0 to zero.
// A synchronous active-low reset starts a clear sweep over every register,
// and ready rises once the sweep has finished.
// Optional macro REGFILE_WSTRB_EN enables byte write strobes (wr_strb).
// When the macro is undefined, wr_strb is ignored and every write is full-width.
module regfile_multiport #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int NUM_RD   = 2,
  parameter int ZERO_REG = 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     wr_en,
  input  logic [ADDR_W-1:0]        wr_addr,
  input  logic [DATA_W-1:0]        wr_data,
  input  logic [DATA_W/8-1:0]      wr_strb,
  input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
  output logic [NUM_RD*DATA_W-1:0] rd_data,
  output logic                     ready
);

  localparam int unsigned DEPTH  = 1 << ADDR_W;
  localparam int unsigned NBYTES = DATA_W / 8;

  typedef enum logic {
    CLEAR = 1'b0,
    READY = 1'b1
  } state_t;

  state_t              state;
  logic [ADDR_W-1:0]   clr_ptr;
  logic [DATA_W-1:0]   regs [DEPTH];

  logic                wrHit;
  logic [DATA_W-1:0]   wrMerged;
  logic                memWe;
  logic [ADDR_W-1:0]   memAddr;
  logic [DATA_W-1:0]   memData;
  logic [NUM_RD*DATA_W-1:0] rdNext;

  // A user write lands only in READY, and never on a hardwired zero register
  always_comb begin
    wrHit = (state == READY) && wr_en;
    if ((ZERO_REG != 0) && (wr_addr == '0)) begin
      wrHit = 1'b0;
    end
  end

`ifdef REGFILE_WSTRB_EN
  // Byte-merge the write data with the current contents under the strobes
  always_comb begin
    wrMerged = regs[wr_addr];
    for (int unsigned b = 0; b < NBYTES; b++) begin
      if (wr_strb[b]) begin
        wrMerged[b*8 +: 8] = wr_data[b*8 +: 8];
      end
    end
  end
`else
  logic unusedStrb;

  // Without strobes every write is full-width
  always_comb begin
    wrMerged   = wr_data;
    unusedStrb = ^wr_strb;
  end
`endif

  // Share the single storage write port between the clear sweep and user writes
  always_comb begin
    memWe   = 1'b0;
    memAddr = wr_addr;
    memData = wrMerged;
    if (state == CLEAR) begin
      memWe   = rst_n;
      memAddr = clr_ptr;
      memData = '0;
    end else if (rst_n) begin
      memWe   = wrHit;
    end
  end

  // Storage array (no reset; the sweep clears it)
  always_ff @(posedge clk) begin
    if (memWe) begin
      regs[memAddr] <= memData;
    end
  end

  // Next read data per port: bypass the in-flight write, force zero on r0
  always_comb begin
    rdNext = '0;
    for (int unsigned p = 0; p < NUM_RD; p++) begin
      logic [ADDR_W-1:0] a;
      a = rd_addr[p*ADDR_W +: ADDR_W];
      if ((ZERO_REG != 0) && (a == '0)) begin
        rdNext[p*DATA_W +: DATA_W] = '0;
      end else if (wrHit && (wr_addr == a)) begin
        rdNext[p*DATA_W +: DATA_W] = wrMerged;
      end else begin
        rdNext[p*DATA_W +: DATA_W] = regs[a];
      end
    end
  end

  // Registered read ports; held at zero during reset and the clear sweep
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rd_data <= '0;
    end else if (state == CLEAR) begin
      rd_data <= '0;
    end else begin
      rd_data <= rdNext;
    end
  end

  // Clear/ready controller: sweep every address once, then flag ready
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= CLEAR;
      clr_ptr <= '0;
      ready   <= 1'b0;
    end else begin
      case (state)
        CLEAR: begin
          clr_ptr <= clr_ptr + 1'b1;
          if (clr_ptr == ADDR_W'(DEPTH - 1)) begin
            state   <= READY;
            ready   <= 1'b1;
            clr_ptr <= '0;
          end
        end
        READY: begin
          ready <= 1'b1;
        end
        default: begin
          state <= CLEAR;
          ready <= 1'b0;
        end
      endcase
    end
  end

endmodule
